gost89_cfb_stream: RTL and testbench

//  Stream front-end for the GOST 28147-89 CFB encrypt/decrypt cores. Accepts a 64-bit IV and a
//  32-bit word stream (valid/ready), packs word pairs into 64-bit blocks and sequences the

---
 rtl/gost89_cfb_stream.sv | 191 +++++++++++++++++++
 tb/tb_gost89_cfb_stream.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gost89_cfb_stream.sv
// gost89_cfb_stream: packs a 32-bit valid/ready word stream into 64-bit blocks for a GOST 28147-89
// CFB core and unpacks results. Define GOST89_CFB_STREAM_STATS_EN to add the o_blk_count counter.
module gost89_cfb_stream #(
    parameter bit          HI_FIRST = 1'b1,
    parameter int unsigned WAIT_MAX = 64
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_iv_valid,
    output logic        o_iv_ready,
    input  logic [63:0] i_iv,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic [31:0] i_in_data,
    input  logic        i_in_last,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [31:0] o_out_data,
    output logic        o_out_last,
    output logic        o_cfb_reset,
    output logic        o_cfb_load,
    output logic [63:0] o_cfb_in,
    input  logic [63:0] i_cfb_out,
    input  logic        i_cfb_busy,
`ifdef GOST89_CFB_STREAM_STATS_EN
    output logic [31:0] o_blk_count,
`endif
    output logic        o_error
);

    localparam int unsigned CntW = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        StIdle, StIvLoad, StCollect, StStart, StWait, StEmit0, StEmit1
    } state_e;

    state_e            r_state;
    logic [31:0]       r_half;
    logic              r_have_half;
    logic              r_n2;
    logic              r_last;
    logic [31:0]       r_res2;
    logic [CntW-1:0]   r_wait_cnt;
    logic              r_iv_ready;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [31:0]       r_out_data;
    logic              r_out_last;
    logic              r_cfb_reset;
    logic              r_cfb_load;
    logic [63:0]       r_cfb_in;
    logic              r_error;
`ifdef GOST89_CFB_STREAM_STATS_EN
    logic [31:0]       r_blk_count;
`endif

    logic [31:0] w_first;
    logic [31:0] w_second;
    logic [63:0] w_block;
    logic [31:0] w_res_first;
    logic [31:0] w_res_second;
    logic        w_wait_expired;

    // A lone last word is padded with a zero second half.
    assign w_first        = r_have_half ? r_half : i_in_data;
    assign w_second       = r_have_half ? i_in_data : 32'h0;
    assign w_block        = HI_FIRST ? {w_first, w_second} : {w_second, w_first};
    assign w_res_first    = HI_FIRST ? i_cfb_out[63:32] : i_cfb_out[31:0];
    assign w_res_second   = HI_FIRST ? i_cfb_out[31:0] : i_cfb_out[63:32];
    assign w_wait_expired = (r_wait_cnt == CntW'(WAIT_MAX - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= StIdle;
            r_half      <= '0;
            r_have_half <= 1'b0;
            r_n2        <= 1'b0;
            r_last      <= 1'b0;
            r_res2      <= '0;
            r_wait_cnt  <= '0;
            r_iv_ready  <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_cfb_reset <= 1'b0;
            r_cfb_load  <= 1'b0;
            r_cfb_in    <= '0;
            r_error     <= 1'b0;
`ifdef GOST89_CFB_STREAM_STATS_EN
            r_blk_count <= '0;
`endif
        end else begin
            r_cfb_reset <= 1'b0;
            r_cfb_load  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    r_iv_ready <= 1'b1;
                    if (r_iv_ready && i_iv_valid) begin
                        r_iv_ready  <= 1'b0;
                        r_cfb_in    <= i_iv;
                        r_cfb_reset <= 1'b1;
                        r_state     <= StIvLoad;
                    end
                end
                StIvLoad: begin
                    r_in_ready  <= 1'b1;
                    r_have_half <= 1'b0;
                    r_state     <= StCollect;
                end
                StCollect: begin
                    if (r_in_ready && i_in_valid) begin
                        if (!r_have_half && !i_in_last) begin
                            r_half      <= i_in_data;
                            r_have_half <= 1'b1;
                        end else begin
                            r_in_ready <= 1'b0;
                            r_n2       <= r_have_half;
                            r_last     <= i_in_last;
                            r_cfb_in   <= w_block;
                            r_cfb_load <= 1'b1;
                            r_state    <= StStart;
                        end
                    end
                end
                StStart: begin
                    r_wait_cnt <= '0;
                    r_state    <= StWait;
                end
                StWait: begin
                    if (!i_cfb_busy) begin
                        r_res2      <= w_res_second;
                        r_out_valid <= 1'b1;
                        r_out_data  <= w_res_first;
                        r_out_last  <= r_last && !r_n2;
                        r_state     <= StEmit0;
`ifdef GOST89_CFB_STREAM_STATS_EN
                        r_blk_count <= r_blk_count + 32'd1;
`endif
                    end else if (w_wait_expired) begin
                        r_error <= 1'b1;
                        r_state <= StIdle;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                StEmit0: begin
                    if (i_out_ready) begin
                        if (r_n2) begin
                            r_out_data <= r_res2;
                            r_out_last <= r_last;
                            r_state    <= StEmit1;
                        end else begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_data  <= '0;
                            r_in_ready  <= !r_last;
                            r_have_half <= 1'b0;
                            r_state     <= r_last ? StIdle : StCollect;
                        end
                    end
                end
                StEmit1: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                        r_out_data  <= '0;
                        r_in_ready  <= !r_last;
                        r_have_half <= 1'b0;
                        r_state     <= r_last ? StIdle : StCollect;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_iv_ready  = r_iv_ready;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_last  = r_out_last;
    assign o_cfb_reset = r_cfb_reset;
    assign o_cfb_load  = r_cfb_load;
    assign o_cfb_in    = r_cfb_in;
    assign o_error     = r_error;
`ifdef GOST89_CFB_STREAM_STATS_EN
    assign o_blk_count = r_blk_count;
`endif

endmodule

// File: tb/tb_gost89_cfb_stream.sv
// Bench for gost89_cfb_stream: two instances (HI_FIRST=1 and 0) each driven into a simple CFB core
// stand-in; outputs are compared against a message-level CFB reference model.
module tb_gost89_cfb_stream;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv_valid[2], iv_ready[2], in_valid[2], in_ready[2], in_last[2];
    logic        out_valid[2], out_ready[2], out_last[2];
    logic        cfb_reset[2], cfb_load[2], cfb_busy[2], error[2];
    logic [63:0] iv[2], cfb_in[2], cfb_out[2];
    logic [31:0] in_data[2], out_data[2];
`ifdef GOST89_CFB_STREAM_STATS_EN
    logic [31:0] blk_count[2];
    int          exp_blk[2];
`endif

    logic [63:0] core_g[2], core_dat[2];
    int          core_cnt[2];
    int          lat[2];
    bit          hang[2];
    bit          dec[2];

    logic [31:0] msg_q[$], exp_q[$], got_q[$], plain_q[$];
    logic        glast_q[$];
    int          load_cyc, err_cyc, extra_valid, valid_cnt, stall_bad, stall_left;
    int          n_checks = 0;
    int          n_err = 0;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        gost89_cfb_stream #(.HI_FIRST(k == 0), .WAIT_MAX(64)) u_dut (
            .i_clk       (clk),
            .i_reset_n   (rst_n),
            .i_iv_valid  (iv_valid[k]),
            .o_iv_ready  (iv_ready[k]),
            .i_iv        (iv[k]),
            .i_in_valid  (in_valid[k]),
            .o_in_ready  (in_ready[k]),
            .i_in_data   (in_data[k]),
            .i_in_last   (in_last[k]),
            .o_out_valid (out_valid[k]),
            .i_out_ready (out_ready[k]),
            .o_out_data  (out_data[k]),
            .o_out_last  (out_last[k]),
            .o_cfb_reset (cfb_reset[k]),
            .o_cfb_load  (cfb_load[k]),
            .o_cfb_in    (cfb_in[k]),
            .i_cfb_out   (cfb_out[k]),
            .i_cfb_busy  (cfb_busy[k]),
`ifdef GOST89_CFB_STREAM_STATS_EN
            .o_blk_count (blk_count[k]),
`endif
            .o_error     (error[k])
        );
    end

    // Stand-in block cipher for the core's gamma generator.
    function automatic logic [63:0] gam(input logic [63:0] g);
        logic [31:0] a, b;
        a = g[63:32];
        b = g[31:0];
        return {b ^ (a * 32'h9E3779B9), {a[18:0], a[31:19]} + b + 32'h5A5A1234};
    endfunction

    // Core stand-in: reset loads gamma, load starts a block, busy for lat+1 cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                cfb_busy[k] <= 1'b0;
                cfb_out[k]  <= '0;
                core_g[k]   <= '0;
                core_dat[k] <= '0;
                core_cnt[k] <= 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (cfb_reset[k]) begin
                    core_g[k] <= cfb_in[k];
                end else if (cfb_load[k]) begin
                    cfb_busy[k] <= 1'b1;
                    core_dat[k] <= cfb_in[k];
                    core_cnt[k] <= lat[k];
                end else if (cfb_busy[k] && !hang[k]) begin
                    if (core_cnt[k] == 0) begin
                        cfb_busy[k] <= 1'b0;
                        cfb_out[k]  <= gam(core_g[k]) ^ core_dat[k];
                        core_g[k]   <= dec[k] ? core_dat[k] : (gam(core_g[k]) ^ core_dat[k]);
                    end else begin
                        core_cnt[k] <= core_cnt[k] - 1;
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Message-level CFB: gamma = E(prev cipher block), padded half dropped from output.
    function automatic void ref_msg(input logic [63:0] v, input bit d, input bit hi);
        logic [63:0] g, blk, o;
        logic [31:0] a, b;
        int n;
        n = msg_q.size();
        g = v;
        exp_q.delete();
        for (int i = 0; i < n; i += 2) begin
            a   = msg_q[i];
            b   = (i + 1 < n) ? msg_q[i+1] : 32'h0;
            blk = hi ? {a, b} : {b, a};
            o   = gam(g) ^ blk;
            g   = d ? blk : o;
            exp_q.push_back(hi ? o[63:32] : o[31:0]);
            if (i + 1 < n) exp_q.push_back(hi ? o[31:0] : o[63:32]);
        end
    endfunction

    task automatic run_msg(input int k, input logic [63:0] v, input int abort_after,
                           input int budget);
        int cyc, idx;
        bit done, acc, held_set;
        logic [31:0] held;
        got_q.delete();
        glast_q.delete();
        load_cyc = -1; err_cyc = -1; extra_valid = 0; valid_cnt = 0; stall_bad = 0;
        held_set = 1'b0;
        held = '0;
        iv[k] = v;
        iv_valid[k] = 1'b1;
        cyc = 0;
        while (!iv_ready[k] && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_val("iv_accept", 64'(iv_ready[k]), 64'd1);
        @(negedge clk);
        iv_valid[k] = 1'b0;
        idx = 0; done = 1'b0; cyc = 0;
        while (!done && cyc < budget) begin
            if (!in_valid[k] && idx < msg_q.size() && $urandom_range(3) != 0) begin
                in_valid[k] = 1'b1;
                in_data[k]  = msg_q[idx];
                in_last[k]  = (idx == msg_q.size() - 1);
            end
            acc = in_valid[k] && in_ready[k];
            if (stall_left > 0 && out_valid[k]) begin
                if (!held_set) begin
                    held = out_data[k];
                    held_set = 1'b1;
                end else if (out_data[k] !== held) begin
                    stall_bad++;
                end
                if (in_ready[k]) stall_bad++;
                out_ready[k] = 1'b0;
                stall_left--;
            end else begin
                out_ready[k] = ($urandom_range(3) != 0);
            end
            if (out_valid[k]) valid_cnt++;
            if (out_valid[k] && out_ready[k]) begin
                got_q.push_back(out_data[k]);
                glast_q.push_back(out_last[k]);
                done = out_last[k];
            end
            if (cfb_load[k] && load_cyc < 0) load_cyc = cyc;
            if (error[k] && err_cyc < 0) err_cyc = cyc;
            if (abort_after > 0 && load_cyc >= 0 && cyc - load_cyc >= abort_after) done = 1'b1;
            @(negedge clk);
            cyc++;
            if (acc) begin
                idx++;
                in_valid[k] = 1'b0;
                in_last[k]  = 1'b0;
            end
        end
        in_valid[k] = 1'b0;
        in_last[k]  = 1'b0;
        if (abort_after == 0) begin
            repeat (4) begin
                @(negedge clk);
                if (out_valid[k]) extra_valid++;
            end
        end
        out_ready[k] = 1'b0;
    endtask

    task automatic compare_msg(input string tag);
        check_val({tag, "_len"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check_val({tag, "_data"}, 64'(got_q[i]), 64'(exp_q[i]));
            check_val({tag, "_last"}, 64'(glast_q[i]), 64'(i == exp_q.size() - 1));
        end
        check_val({tag, "_extra"}, 64'(extra_valid), 64'd0);
    endtask

    task automatic do_msg(input int k, input logic [63:0] v, input bit d, input string tag);
        dec[k] = d;
        lat[k] = $urandom_range(0, 40);
        ref_msg(v, d, k == 0);
        run_msg(k, v, 0, 1000);
        compare_msg(tag);
`ifdef GOST89_CFB_STREAM_STATS_EN
        exp_blk[k] += (msg_q.size() + 1) / 2;
`endif
    endtask

    task automatic fill_msg(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back($urandom());
    endtask

    initial begin
        rst_n = 1'b1;
        stall_left = 0;
        for (int k = 0; k < 2; k++) begin
            iv_valid[k] = 1'b0; iv[k] = '0; in_valid[k] = 1'b0; in_data[k] = '0;
            in_last[k] = 1'b0; out_ready[k] = 1'b0; lat[k] = 0; hang[k] = 1'b0; dec[k] = 1'b0;
`ifdef GOST89_CFB_STREAM_STATS_EN
            exp_blk[k] = 0;
`endif
        end
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val("rst_ctl", 64'({iv_ready[k], in_ready[k], out_valid[k], out_last[k],
                                      cfb_reset[k], cfb_load[k], error[k]}), 64'd0);
            check_val("rst_data", {out_data[k], 32'h0} | cfb_in[k], 64'd0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle_iv_ready", 64'(iv_ready[0]), 64'd1);

        fill_msg(2);
        do_msg(0, 64'h0123456789ABCDEF, 1'b0, "t1");
        fill_msg(3);
        do_msg(0, {$urandom(), $urandom()}, 1'b0, "t2");

        fill_msg(4);
        stall_left = 10;
        do_msg(0, {$urandom(), $urandom()}, 1'b1, "t3");
        check_val("t3_stall_hold", 64'(stall_bad), 64'd0);
        check_val("t3_stall_done", 64'(stall_left), 64'd0);
        stall_left = 0;

        for (int i = 0; i < 6; i++) begin
            fill_msg($urandom_range(1, 7));
            do_msg(i % 2, {$urandom(), $urandom()}, 1'($urandom_range(1)), "rand");
        end

        // Core never finishes: watchdog must fire after WAIT_MAX wait cycles.
        hang[0] = 1'b1;
        fill_msg(2);
        dec[0] = 1'b0;
        run_msg(0, {$urandom(), $urandom()}, 0, 120);
        check_val("t4_no_out", 64'(valid_cnt + extra_valid), 64'd0);
        check_val("t4_wd_cycles", 64'(err_cyc - load_cyc), 64'd65);
        check_val("t4_error", 64'(error[0]), 64'd1);
        check_val("t4_idle", 64'(iv_ready[0]), 64'd1);
        hang[0] = 1'b0;

        fill_msg(2);
        lat[0] = 30;
        run_msg(0, {$urandom(), $urandom()}, 5, 200);
        #3 rst_n = 1'b0;
        #1;
        check_val("t5_rst_ctl", 64'({iv_ready[0], in_ready[0], out_valid[0], out_last[0],
                                     cfb_reset[0], cfb_load[0], error[0]}), 64'd0);
        check_val("t5_rst_data", {out_data[0], 32'h0} | cfb_in[0], 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
`ifdef GOST89_CFB_STREAM_STATS_EN
        exp_blk[0] = 0;
        exp_blk[1] = 0;
`endif
        fill_msg(2);
        do_msg(0, {$urandom(), $urandom()}, 1'b0, "t5");

        fill_msg(8);
        plain_q = msg_q;
        do_msg(1, 64'hFEDCBA9876543210, 1'b0, "t6_enc");
        msg_q = got_q;
        do_msg(1, 64'hFEDCBA9876543210, 1'b1, "t6_dec");
        check_val("t6_loop_len", 64'(got_q.size()), 64'd8);
        for (int i = 0; i < plain_q.size() && i < got_q.size(); i++)
            check_val("t6_loop", 64'(got_q[i]), 64'(plain_q[i]));
`ifdef GOST89_CFB_STREAM_STATS_EN
        check_val("blk_count_lo", 64'(blk_count[1]), 64'd8);
        check_val("blk_count_hi", 64'(blk_count[0]), 64'(exp_blk[0]));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
